// File: rtl/fullchip_seq.sv
// rtl/fullchip_seq.sv - single-clock instruction sequencer for the two-core attention chip
// Optional ack timeout: FULLCHIP_SEQ_ACK_TIMEOUT_EN
module fullchip_seq #(
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  input  logic        ack_in_core0,
  input  logic        ack_in_core1,
  output logic [16:0] inst,
  output logic        acc_core0,
  output logic        acc_core1,
  output logic        div_core0,
  output logic        div_core1,
  output logic        sel_pmem_core0,
  output logic        sel_pmem_core1,
  output logic        req_out_core0,
  output logic        req_out_core1,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_QWR      = 4'd1;
  localparam logic [3:0] S_KWR      = 4'd2;
  localparam logic [3:0] S_KLOAD    = 4'd3;
  localparam logic [3:0] S_EXEC     = 4'd4;
  localparam logic [3:0] S_DRAIN    = 4'd5;
  localparam logic [3:0] S_NORM_RD  = 4'd6;
  localparam logic [3:0] S_NORM_ACC = 4'd7;
  localparam logic [3:0] S_NORM_REQ = 4'd8;
  localparam logic [3:0] S_NORM_DIV = 4'd9;
  localparam logic [3:0] S_DONE     = 4'd10;

  localparam logic [3:0] col_last = 4'(col - 1);
  localparam logic [3:0] tc_last  = 4'(total_cycle - 1);

  logic [3:0]  state, nxt_state;
  logic [3:0]  i_cnt, nxt_i;
  logic [3:0]  p_cnt, nxt_p;
  logic [3:0]  r_cnt, nxt_r;
  logic        ack0_seen, ack1_seen, nxt_ack0, nxt_ack1;
  logic        ack0_now, ack1_now;
  logic        start_ok;
  logic        timeout_hit;
  logic [16:0] nxt_inst;
  logic        acc_q, div_q, sel_q, req_q;
  logic        nxt_acc, nxt_div, nxt_sel, nxt_req, nxt_busy, nxt_done;

  // A pending ack counts as seen if it was latched earlier or is high right now.
  assign ack0_now = ack0_seen | ack_in_core0;
  assign ack1_now = ack1_seen | ack_in_core1;
  assign start_ok = (state == S_IDLE) && start;

`ifdef FULLCHIP_SEQ_ACK_TIMEOUT_EN
  logic [15:0] req_cycles;

  always_ff @(posedge clk) begin
    if (reset || state != S_NORM_REQ) req_cycles <= '0;
    else                              req_cycles <= req_cycles + 16'd1;
  end

  assign timeout_hit = (req_cycles == 16'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset || start_ok) err <= 1'b0;
    else if (state == S_NORM_REQ && !(ack0_now && ack1_now) && timeout_hit) err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    nxt_i     = i_cnt;
    nxt_p     = p_cnt;
    nxt_r     = r_cnt;
    nxt_ack0  = 1'b0;
    nxt_ack1  = 1'b0;
    case (state)
      S_IDLE: if (start) begin nxt_state = S_QWR; nxt_i = '0; end
      S_QWR:
        if (i_cnt == tc_last) begin nxt_state = S_KWR; nxt_i = '0; end
        else nxt_i = i_cnt + 4'd1;
      S_KWR:
        if (i_cnt == col_last) begin nxt_state = S_KLOAD; nxt_i = '0; end
        else nxt_i = i_cnt + 4'd1;
      S_KLOAD:
        if (i_cnt == col_last) begin nxt_state = S_EXEC; nxt_i = '0; end
        else nxt_i = i_cnt + 4'd1;
      S_EXEC:
        if (i_cnt == tc_last) begin nxt_state = S_DRAIN; nxt_p = '0; end
        else nxt_i = i_cnt + 4'd1;
      // p advances only once the pop driven this cycle has actually happened.
      S_DRAIN:
        if (inst[16]) begin
          if (p_cnt == tc_last) begin nxt_state = S_NORM_RD; nxt_r = '0; end
          else nxt_p = p_cnt + 4'd1;
        end
      S_NORM_RD:  nxt_state = S_NORM_ACC;
      S_NORM_ACC: nxt_state = S_NORM_REQ;
      S_NORM_REQ:
        if (ack0_now && ack1_now) nxt_state = S_NORM_DIV;
        else if (timeout_hit)     nxt_state = S_DONE;
        else begin nxt_ack0 = ack0_now; nxt_ack1 = ack1_now; end
      S_NORM_DIV:
        if (r_cnt == tc_last) nxt_state = S_DONE;
        else begin nxt_state = S_NORM_RD; nxt_r = r_cnt + 4'd1; end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Control word for the cycle we are about to enter, so every output is a flop.
  always_comb begin
    nxt_inst = '0;
    nxt_acc  = 1'b0;
    nxt_div  = 1'b0;
    nxt_sel  = 1'b0;
    nxt_req  = 1'b0;
    nxt_done = 1'b0;
    nxt_busy = (nxt_state != S_IDLE);
    case (nxt_state)
      S_QWR:      nxt_inst = {1'b0, nxt_i, 4'h0, 8'h10};
      S_KWR:      nxt_inst = {1'b0, nxt_i, 4'h0, 8'h04};
      S_KLOAD:    nxt_inst = {1'b0, nxt_i, 4'h0, 8'h48};
      S_EXEC:     nxt_inst = {1'b0, nxt_i, 4'h0, 8'hA0};
      S_DRAIN:    if (ofifo_valid) nxt_inst = {1'b1, 4'h0, nxt_p, 8'h01};
      S_NORM_RD:  begin nxt_inst = {5'h00, nxt_r, 8'h02}; nxt_sel = 1'b1; end
      S_NORM_ACC: begin nxt_acc = 1'b1; nxt_sel = 1'b1; end
      S_NORM_REQ: begin nxt_req = 1'b1; nxt_sel = 1'b1; end
      S_NORM_DIV: begin nxt_div = 1'b1; nxt_sel = 1'b1; end
      S_DONE:     nxt_done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      i_cnt     <= '0;
      p_cnt     <= '0;
      r_cnt     <= '0;
      ack0_seen <= 1'b0;
      ack1_seen <= 1'b0;
      inst      <= '0;
      acc_q     <= 1'b0;
      div_q     <= 1'b0;
      sel_q     <= 1'b0;
      req_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nxt_state;
      i_cnt     <= nxt_i;
      p_cnt     <= nxt_p;
      r_cnt     <= nxt_r;
      ack0_seen <= nxt_ack0;
      ack1_seen <= nxt_ack1;
      inst      <= nxt_inst;
      acc_q     <= nxt_acc;
      div_q     <= nxt_div;
      sel_q     <= nxt_sel;
      req_q     <= nxt_req;
      busy      <= nxt_busy;
      done      <= nxt_done;
    end
  end

  assign acc_core0      = acc_q;
  assign acc_core1      = acc_q;
  assign div_core0      = div_q;
  assign div_core1      = div_q;
  assign sel_pmem_core0 = sel_q;
  assign sel_pmem_core1 = sel_q;
  assign req_out_core0  = req_q;
  assign req_out_core1  = req_q;

endmodule

// File: tb/tb_fullchip_seq.sv
// tb/tb_fullchip_seq.sv - randomized self-checking bench for fullchip_seq against a phase-list model
module tb_fullchip_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset;
  logic        start, ofifo_valid, ack0, ack1;
  logic [16:0] inst_o [2];
  logic        acc0_o [2], acc1_o [2], div0_o [2], div1_o [2];
  logic        sel0_o [2], sel1_o [2], req0_o [2], req1_o [2];
  logic        busy_o [2], done_o [2], err_o [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_w [0:1023];
  bit          sv [0:1023];
  bit          sa0 [0:1023];
  bit          sa1 [0:1023];
  bit          sst [0:1023];
  bit          srst [0:1023];
  int          last_c, exp_done_c, exp_divs;
  bit          err_cur [2];

  fullchip_seq #(.col(8), .total_cycle(8), .TIMEOUT(64)) u0 (
    .clk(clk), .reset(reset[0]), .start(start), .ofifo_valid(ofifo_valid),
    .ack_in_core0(ack0), .ack_in_core1(ack1), .inst(inst_o[0]),
    .acc_core0(acc0_o[0]), .acc_core1(acc1_o[0]), .div_core0(div0_o[0]), .div_core1(div1_o[0]),
    .sel_pmem_core0(sel0_o[0]), .sel_pmem_core1(sel1_o[0]),
    .req_out_core0(req0_o[0]), .req_out_core1(req1_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
  );

  fullchip_seq #(.col(5), .total_cycle(16), .TIMEOUT(64)) u1 (
    .clk(clk), .reset(reset[1]), .start(start), .ofifo_valid(ofifo_valid),
    .ack_in_core0(ack0), .ack_in_core1(ack1), .inst(inst_o[1]),
    .acc_core0(acc0_o[1]), .acc_core1(acc1_o[1]), .div_core0(div0_o[1]), .div_core1(div1_o[1]),
    .sel_pmem_core0(sel0_o[1]), .sel_pmem_core1(sel1_o[1]),
    .req_out_core0(req0_o[1]), .req_out_core1(req1_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [16:0] w, input bit acc, input bit dv,
                                       input bit sel, input bit req, input bit bsy,
                                       input bit dn, input bit er);
    return {4'b0, er, dn, bsy, req, req, sel, sel, dv, dv, acc, acc, w};
  endfunction

  function automatic logic [31:0] observe(input int d);
    return {4'b0, err_o[d], done_o[d], busy_o[d], req1_o[d], req0_o[d], sel1_o[d], sel0_o[d],
            div1_o[d], div0_o[d], acc1_o[d], acc0_o[d], inst_o[d]};
  endfunction

  // vmode: 0 valid always, 1 random, 2 toggling. amode: 0 immediate acks, 1 random delays,
  // 2 ack0 at +2 / ack1 at +5, 3 no acks at all (timeout).
  task automatic build(input int d, input int vmode, input int amode, input int abort_at);
    int c, ncol, ntc, pops, d0, d1, dm;
    bit er;
    ncol = (d == 0) ? 5 + 3 : 5;
    ntc  = (d == 0) ? 8 : 16;
    for (int k = 0; k < 1024; k++) begin
      sv[k]   = (vmode == 0) ? 1'b1 : (vmode == 2) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      sa0[k]  = ($urandom_range(0, 3) == 0);
      sa1[k]  = ($urandom_range(0, 3) == 0);
      sst[k]  = 1'b0;
      srst[k] = 1'b0;
    end
    er = err_cur[d];
    exp_w[0] = pack(17'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, er);
    sst[0] = 1'b1;
    er = 1'b0;
    c = 1;
    exp_divs = 0;
    for (int k = 0; k < ntc; k++) begin exp_w[c] = pack({1'b0, 4'(k), 4'h0, 8'h10}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er); c++; end
    for (int k = 0; k < ncol; k++) begin exp_w[c] = pack({1'b0, 4'(k), 4'h0, 8'h04}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er); c++; end
    for (int k = 0; k < ncol; k++) begin exp_w[c] = pack({1'b0, 4'(k), 4'h0, 8'h48}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er); c++; end
    for (int k = 0; k < ntc; k++) begin exp_w[c] = pack({1'b0, 4'(k), 4'h0, 8'hA0}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er); c++; end
    pops = 0;
    while (pops < ntc) begin
      if (sv[c-1]) begin
        exp_w[c] = pack({1'b1, 4'h0, 4'(pops), 8'h01}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er);
        pops++;
      end else begin
        exp_w[c] = pack(17'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er);
      end
      c++;
    end
    for (int r = 0; r < ntc; r++) begin
      exp_w[c] = pack({5'h00, 4'(r), 8'h02}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, er); c++;
      exp_w[c] = pack(17'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, er); c++;
      if (amode == 3) begin
        for (int j = 0; j <= 64; j++) begin
          sa0[c] = 1'b0; sa1[c] = 1'b0;
          exp_w[c] = pack(17'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, er); c++;
        end
        er = 1'b1;
        break;
      end
      d0 = (amode == 0) ? 0 : (amode == 2) ? 2 : int'($urandom_range(0, 5));
      d1 = (amode == 0) ? 0 : (amode == 2) ? 5 : int'($urandom_range(0, 5));
      dm = (d0 > d1) ? d0 : d1;
      for (int j = 0; j <= dm; j++) begin
        sa0[c+j] = (j == d0);
        sa1[c+j] = (j == d1);
        exp_w[c+j] = pack(17'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, er);
      end
      c += dm + 1;
      exp_w[c] = pack(17'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, er); c++;
      exp_divs++;
    end
    exp_done_c = c;
    exp_w[c] = pack(17'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, er);
    for (int k = 1; k <= c; k++) sst[k] = ($urandom_range(0, 3) == 0);
    exp_w[c+1] = pack(17'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, er);
    last_c = c + 1;
    err_cur[d] = er;
    if (abort_at > 0) begin
      srst[abort_at] = 1'b1;
      sst[abort_at+1] = 1'b0;
      exp_w[abort_at+1] = 32'h0;
      last_c = abort_at + 1;
      err_cur[d] = 1'b0;
    end
  endtask

  task automatic run_pass(input int d, input int vmode, input int amode, input int abort_at,
                          output int done_seen);
    int npop, ndiv, ntc;
    ntc = (d == 0) ? 8 : 16;
    build(d, vmode, amode, abort_at);
    npop = 0;
    ndiv = 0;
    done_seen = -1;
    err_cur[1-d] = 1'b0;
    reset[1-d] = 1'b1;
    for (int c = 0; c <= last_c; c++) begin
      start = sst[c]; ofifo_valid = sv[c]; ack0 = sa0[c]; ack1 = sa1[c]; reset[d] = srst[c];
      check_eq($sformatf("d%0d_v%0d_a%0d_c%0d", d, vmode, amode, c), observe(d), exp_w[c]);
      if (inst_o[d][16] === 1'b1) npop++;
      if (div0_o[d] === 1'b1) ndiv++;
      if (done_o[d] === 1'b1 && done_seen < 0) done_seen = c;
      @(posedge clk); #1;
    end
    start = 1'b0; ack0 = 1'b0; ack1 = 1'b0; ofifo_valid = 1'b0; reset[d] = 1'b0;
    if (abort_at == 0) begin
      check_eq($sformatf("pops_d%0d", d), npop, ntc);
      check_eq($sformatf("divs_d%0d", d), ndiv, exp_divs);
      check_eq($sformatf("done_cycle_d%0d", d), done_seen, exp_done_c);
    end
  endtask

  initial begin
    int ds;
    reset = 2'b11; start = 1'b1; ofifo_valid = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
    err_cur[0] = 1'b0; err_cur[1] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("reset_d0_%0d", k), observe(0), 32'h0);
      check_eq($sformatf("reset_d1_%0d", k), observe(1), 32'h0);
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 2'b00;

    run_pass(0, 0, 0, 0, ds);
    check_eq("done_at_73", ds, 73);
    run_pass(0, 2, 2, 0, ds);
    for (int n = 0; n < 3; n++) run_pass(0, 1, 1, 0, ds);
    run_pass(0, 0, 1, 27, ds);
    run_pass(0, 1, 1, 0, ds);
`ifdef FULLCHIP_SEQ_ACK_TIMEOUT_EN
    run_pass(0, 1, 3, 0, ds);
    run_pass(0, 0, 0, 0, ds);
`endif
    for (int n = 0; n < 3; n++) run_pass(1, 1, 1, 0, ds);
    run_pass(1, 2, 2, 35, ds);
    run_pass(1, 1, 1, 0, ds);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
